// File: rtl/shortcut_preset_setter.sv
// Accumulates preset-key seconds, then adds them to a BCD hh:mm:ss base one second per clock.
// Latency: sharp edge sampled at edge n -> result and completeSetting valid after edge n+2+P.
// Backpressure: none; keys and sharp are ignored outside COLLECT. SHORTCUT_SATURATE_EN holds 23:59:59 instead of wrapping.
module shortcut_preset_setter #(
    parameter int NUM_KEYS    = 10,
    parameter int UNIT_SEC    = 5,
    parameter int MAX_PENDING = 3599
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [NUM_KEYS-1:0] keypad,
    input  logic                sharp,
    input  logic [3:0]          hour_ten_in,
    input  logic [3:0]          hour_one_in,
    input  logic [3:0]          min_ten_in,
    input  logic [3:0]          min_one_in,
    input  logic [3:0]          sec_ten_in,
    input  logic [3:0]          sec_one_in,
    output logic [3:0]          hour_ten_out,
    output logic [3:0]          hour_one_out,
    output logic [3:0]          min_ten_out,
    output logic [3:0]          min_one_out,
    output logic [3:0]          sec_ten_out,
    output logic [3:0]          sec_one_out,
    output logic                completeSetting,
    output logic                busy
);
    localparam int PW = $clog2(MAX_PENDING + 1);
`ifdef SHORTCUT_SATURATE_EN
    localparam bit SATURATE = 1'b1;
`else
    localparam bit SATURATE = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, COLLECT, ADD, DONE} state_t;
    typedef struct packed {
        logic [3:0] ht, ho, mt, mo, st, so;
    } bcd_time_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     p_q, p_d;
    bcd_time_t         w_q, w_d, out_q, out_d, base_in;
    logic              done_q, done_d;
    logic [NUM_KEYS-1:0] key_q, key_qq, key_press;
    logic              sharp_q, sharp_qq, sharp_press;
    logic              key_hit, base_ok;
    logic [31:0]       key_step, p_sum;
    logic [PW-1:0]     p_add;

    function automatic bcd_time_t inc_time(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (SATURATE && t == 24'h235959) begin
            r = t;
        end else if (t.so != 4'd9) begin
            r.so = t.so + 4'd1;
        end else begin
            r.so = 4'd0;
            if (t.st != 4'd5) begin
                r.st = t.st + 4'd1;
            end else begin
                r.st = 4'd0;
                if (t.mo != 4'd9) begin
                    r.mo = t.mo + 4'd1;
                end else begin
                    r.mo = 4'd0;
                    if (t.mt != 4'd5) begin
                        r.mt = t.mt + 4'd1;
                    end else begin
                        r.mt = 4'd0;
                        if (t.ht == 4'd2 && t.ho == 4'd3) begin
                            r.ht = 4'd0;
                            r.ho = 4'd0;
                        end else if (t.ho == 4'd9) begin
                            r.ho = 4'd0;
                            r.ht = t.ht + 4'd1;
                        end else begin
                            r.ho = t.ho + 4'd1;
                        end
                    end
                end
            end
        end
        return r;
    endfunction

    assign base_in     = {hour_ten_in, hour_one_in, min_ten_in, min_one_in, sec_ten_in, sec_one_in};
    assign base_ok     = (base_in.ht <= 4'd2) && (base_in.ho <= 4'd9) && (base_in.mt <= 4'd5) &&
                         (base_in.mo <= 4'd9) && (base_in.st <= 4'd5) && (base_in.so <= 4'd9) &&
                         !(base_in.ht == 4'd2 && base_in.ho > 4'd3);
    assign key_press   = key_q & ~key_qq;
    assign sharp_press = sharp_q & ~sharp_qq;

    // Scan downwards so the lowest pressed index is the one left standing.
    always_comb begin
        key_hit  = 1'b0;
        key_step = 32'd0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (key_press[i]) begin
                key_hit  = 1'b1;
                key_step = 32'((i + 1) * UNIT_SEC);
            end
        end
    end

    assign p_sum = 32'(p_q) + key_step;
    assign p_add = (p_sum > 32'(MAX_PENDING)) ? PW'(MAX_PENDING) : PW'(p_sum);

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        w_d     = w_q;
        out_d   = out_q;
        done_d  = done_q;
        if (!en) begin
            state_d = IDLE;
            p_d     = '0;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    p_d     = '0;
                    state_d = COLLECT;
                end
                COLLECT: begin
                    if (sharp_press) begin
                        state_d = ADD;
                        w_d     = base_ok ? base_in : '0;
                    end else if (key_hit) begin
                        p_d = p_add;
                    end
                end
                ADD: begin
                    if (p_q != '0) begin
                        w_d = inc_time(w_q);
                        p_d = p_q - PW'(1);
                    end else begin
                        state_d = DONE;
                        out_d   = w_q;
                        done_d  = 1'b1;
                    end
                end
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            p_q      <= '0;
            w_q      <= '0;
            out_q    <= '0;
            done_q   <= 1'b0;
            key_q    <= '0;
            key_qq   <= '0;
            sharp_q  <= 1'b0;
            sharp_qq <= 1'b0;
        end else begin
            state_q  <= state_d;
            p_q      <= p_d;
            w_q      <= w_d;
            out_q    <= out_d;
            done_q   <= done_d;
            key_q    <= keypad;
            key_qq   <= key_q;
            sharp_q  <= sharp;
            sharp_qq <= sharp_q;
        end
    end

    assign {hour_ten_out, hour_one_out, min_ten_out, min_one_out, sec_ten_out, sec_one_out} = out_q;
    assign completeSetting = done_q;
    assign busy            = (state_q == ADD);
endmodule

// File: tb/tb_shortcut_preset_setter.sv
// Bench for shortcut_preset_setter: table vectors, corner sequences and random sessions vs a seconds-based model.
module tb_shortcut_preset_setter;
    logic       clk = 1'b0, rst = 1'b0, en = 1'b0, sharp = 1'b0;
    logic [9:0] keypad = '0;
    logic [23:0] base = '0;
    logic [3:0] a_ht, a_ho, a_mt, a_mo, a_st, a_so, b_ht, b_ho, b_mt, b_mo, b_st, b_so;
    logic       c1, b1, c2, b2;
    logic [23:0] t1, t2, obs_time;
    logic       obs_c, obs_b;
    bit         sel = 1'b0;
    int         checks = 0, errors = 0;

    always #5 clk = ~clk;

    shortcut_preset_setter u_dut (
        .clk(clk), .rst(rst), .en(en), .keypad(keypad), .sharp(sharp),
        .hour_ten_in(base[23:20]), .hour_one_in(base[19:16]), .min_ten_in(base[15:12]),
        .min_one_in(base[11:8]), .sec_ten_in(base[7:4]), .sec_one_in(base[3:0]),
        .hour_ten_out(a_ht), .hour_one_out(a_ho), .min_ten_out(a_mt), .min_one_out(a_mo),
        .sec_ten_out(a_st), .sec_one_out(a_so), .completeSetting(c1), .busy(b1));

    shortcut_preset_setter #(.MAX_PENDING(20)) u_dut20 (
        .clk(clk), .rst(rst), .en(en), .keypad(keypad), .sharp(sharp),
        .hour_ten_in(base[23:20]), .hour_one_in(base[19:16]), .min_ten_in(base[15:12]),
        .min_one_in(base[11:8]), .sec_ten_in(base[7:4]), .sec_one_in(base[3:0]),
        .hour_ten_out(b_ht), .hour_one_out(b_ho), .min_ten_out(b_mt), .min_one_out(b_mo),
        .sec_ten_out(b_st), .sec_one_out(b_so), .completeSetting(c2), .busy(b2));

    assign t1 = {a_ht, a_ho, a_mt, a_mo, a_st, a_so};
    assign t2 = {b_ht, b_ho, b_mt, b_mo, b_st, b_so};
    assign obs_time = sel ? t2 : t1;
    assign obs_c    = sel ? c2 : c1;
    assign obs_b    = sel ? b2 : b1;

    typedef struct {
        logic [23:0]      base;
        int               n;
        logic [3:0][9:0]  keys;
        logic [23:0]      exp;
        int               lat;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit bcd_valid(input logic [23:0] b);
        int h;
        h = int'(b[23:20]) * 10 + int'(b[19:16]);
        return b[23:20] <= 9 && b[19:16] <= 9 && b[15:12] <= 5 && b[11:8] <= 9 &&
               b[7:4] <= 5 && b[3:0] <= 9 && h <= 23;
    endfunction

    function automatic int to_sec(input logic [23:0] b);
        return (int'(b[23:20]) * 10 + int'(b[19:16])) * 3600 +
               (int'(b[15:12]) * 10 + int'(b[11:8])) * 60 + int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [23:0] from_sec(input int s);
        int h, m, x;
        h = s / 3600; m = (s / 60) % 60; x = s % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
    endfunction

    // Ends positioned just after the edge that samples the sharp rise.
    task automatic start_session(input logic [23:0] b, input logic [3:0][9:0] keys, input int n);
        @(negedge clk); en = 1'b0; sharp = 1'b0; keypad = '0; base = b;
        @(negedge clk); en = 1'b1;
        @(negedge clk); @(negedge clk);
        for (int i = 0; i < n; i++) begin
            keypad = keys[i];
            @(negedge clk); @(negedge clk);
            keypad = '0;
            @(negedge clk); @(negedge clk);
        end
        sharp = 1'b1;
        @(posedge clk);
    endtask

    task automatic run_session(input string name, input logic [23:0] exp_t, input int exp_lat);
        int cyc, busy_cnt;
        bit stable, done;
        logic [23:0] prior;
        cyc = 0; busy_cnt = 0; stable = 1'b1; done = 1'b0;
        #1 prior = obs_time;
        while (!done && cyc < 5000) begin
            @(posedge clk); #1;
            cyc++;
            if (obs_b) busy_cnt++;
            if (obs_c) done = 1'b1;
            else if (obs_time !== prior) stable = 1'b0;
        end
        check({name, "_done"}, 32'(done), 32'd1);
        check({name, "_latency"}, 32'(cyc), 32'(exp_lat));
        check({name, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_lat - 1));
        check({name, "_time"}, 32'(obs_time), 32'(exp_t));
        check({name, "_stable_before_done"}, 32'(stable), 32'd1);
    endtask

    initial begin
        logic [3:0][9:0] keys;
        logic [9:0] one;
        logic [23:0] rb, exp_t;
        int n, p, tot, k;
        one = 10'd1;

        repeat (3) @(negedge clk);
        check("reset_time", 32'(t1), 32'd0);
        check("reset_complete", 32'(c1), 32'd0);
        check("reset_busy", 32'(b1), 32'd0);
        check("reset_time20", 32'(t2), 32'd0);
        rst = 1'b1;

        vecs[0] = '{24'h123450, 1, {10'h000, 10'h000, 10'h000, 10'h004}, 24'h123505, 17};
        vecs[1] = '{24'h100000, 4, {10'h200, 10'h001, 10'h001, 10'h001}, 24'h100105, 67};
`ifdef SHORTCUT_SATURATE_EN
        vecs[2] = '{24'h235958, 1, {10'h000, 10'h000, 10'h000, 10'h001}, 24'h235959, 7};
`else
        vecs[2] = '{24'h235958, 1, {10'h000, 10'h000, 10'h000, 10'h001}, 24'h000003, 7};
`endif
        vecs[3] = '{24'h070809, 0, {10'h000, 10'h000, 10'h000, 10'h000}, 24'h070809, 2};
        vecs[4] = '{24'h250000, 0, {10'h000, 10'h000, 10'h000, 10'h000}, 24'h000000, 2};
        vecs[5] = '{24'h000000, 1, {10'h000, 10'h000, 10'h000, 10'h028}, 24'h000020, 22};

        sel = 1'b0;
        for (int i = 0; i < 6; i++) begin
            start_session(vecs[i].base, vecs[i].keys, vecs[i].n);
            run_session($sformatf("vec%0d", i), vecs[i].exp, vecs[i].lat);
        end

        // Abort 5 cycles into ADD: last committed result (00:00:20) must survive.
        keys = {10'h000, 10'h000, 10'h000, 10'h200};
        start_session(24'h010000, keys, 1);
        repeat (6) @(posedge clk);
        #1 check("endrop_in_add", 32'(b1), 32'd1);
        @(negedge clk); en = 1'b0;
        @(posedge clk); #1;
        check("endrop_busy", 32'(b1), 32'd0);
        check("endrop_complete", 32'(c1), 32'd0);
        check("endrop_time", 32'(t1), 32'h000020);
        repeat (60) @(posedge clk);
        #1 check("endrop_complete_later", 32'(c1), 32'd0);
        check("endrop_time_later", 32'(t1), 32'h000020);

        sel = 1'b1;
        keys = {10'h000, 10'h000, 10'h200, 10'h200};
        start_session(24'h000000, keys, 2);
        run_session("pending_sat20", 24'h000020, 22);
        sel = 1'b0;

        for (int r = 0; r < 20; r++) begin
            rb = ($urandom_range(0, 3) == 0) ? 24'($urandom) : from_sec(int'($urandom_range(0, 86399)));
            n = int'($urandom_range(0, 4));
            keys = '0;
            p = 0;
            for (int i = 0; i < n; i++) begin
                k = int'($urandom_range(0, 9));
                keys[i] = one << k;
                p = p + (k + 1) * 5;
                if (p > 3599) p = 3599;
            end
            tot = (bcd_valid(rb) ? to_sec(rb) : 0) + p;
`ifdef SHORTCUT_SATURATE_EN
            if (tot > 86399) tot = 86399;
`else
            tot = tot % 86400;
`endif
            exp_t = from_sec(tot);
            start_session(rb, keys, n);
            run_session($sformatf("rand%0d", r), exp_t, p + 2);
        end

        keys = {10'h000, 10'h000, 10'h000, 10'h200};
        start_session(24'h120000, keys, 1);
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("rstadd_time", 32'(t1), 32'd0);
        check("rstadd_complete", 32'(c1), 32'd0);
        check("rstadd_busy", 32'(b1), 32'd0);
        @(negedge clk); rst = 1'b1; en = 1'b0; sharp = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
